// File: rtl/clock_frequency_monitor.sv
// Measures how many clk_in cycles span NUM_PERIODS rising edges of an asynchronous clk_test.
// Define CLK_MON_CONTINUOUS_EN for back-to-back windows with start acting as a level enable.
module clock_frequency_monitor #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned NUM_PERIODS  = 4,
  parameter int unsigned EXPECTED_DIV = 4,
  parameter int unsigned TIMEOUT      = 1024
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clk_test,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period_count,
  output logic             match,
  output logic             timeout
);

`ifdef CLK_MON_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  localparam int unsigned     WD_W      = $clog2(TIMEOUT + 1);
  localparam longint unsigned EXP_CNT   = longint'(NUM_PERIODS) * longint'(EXPECTED_DIV);
  localparam bit              EXP_FITS  = (CNT_W >= 64) || (EXP_CNT < (64'd1 << CNT_W));
  localparam logic [CNT_W-1:0] EXP_VAL  = CNT_W'(EXP_CNT);
  localparam logic [7:0]      LAST_EDGE = 8'(NUM_PERIODS - 1);

  typedef enum logic [1:0] {StIdle, StWaitEdge, StMeasure, StDone} state_e;

  state_e           r_state, w_state_d;
  logic             r_sync1, r_sync2, r_hist;
  logic             w_edge;
  logic [CNT_W-1:0] r_cnt, w_cnt_d, w_cnt_inc;
  logic             w_cnt_sat;
  logic [7:0]       r_edge_cnt, w_edge_cnt_d;
  logic [WD_W-1:0]  r_wdog, w_wdog_d, w_wdog_inc;
  logic             w_wdog_expire;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic [CNT_W-1:0] r_period, w_period_d;
  logic             r_match, w_match_d;
  logic             r_timeout, w_timeout_d;

  assign w_edge        = r_sync2 & ~r_hist;
  assign w_cnt_sat     = &r_cnt;
  assign w_cnt_inc     = w_cnt_sat ? r_cnt : r_cnt + CNT_W'(1);
  assign w_wdog_inc    = r_wdog + WD_W'(1);
  assign w_wdog_expire = (w_wdog_inc == WD_W'(TIMEOUT));

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_edge_cnt_d = r_edge_cnt;
    w_wdog_d     = r_wdog;
    w_busy_d     = r_busy;
    w_done_d     = 1'b0;
    w_period_d   = r_period;
    w_match_d    = r_match;
    w_timeout_d  = r_timeout;

    unique case (r_state)
      StIdle: begin
        w_busy_d = 1'b0;
        if (start) begin
          w_state_d    = StWaitEdge;
          w_wdog_d     = '0;
          w_edge_cnt_d = '0;
          w_busy_d     = 1'b1;
        end
      end

      StWaitEdge: begin
        w_wdog_d = w_wdog_inc;
        if (w_edge) begin
          w_cnt_d   = '0;
          w_wdog_d  = '0;
          w_state_d = StMeasure;
        end else if (w_wdog_expire) begin
          w_state_d   = StDone;
          w_done_d    = 1'b1;
          w_busy_d    = CONT;
          w_period_d  = '0;
          w_match_d   = 1'b0;
          w_timeout_d = 1'b1;
        end
      end

      StMeasure: begin
        w_cnt_d  = w_cnt_inc;
        w_wdog_d = w_wdog_inc;
        // An edge in the same cycle as watchdog expiry takes priority.
        if (w_edge) begin
          w_wdog_d     = '0;
          w_edge_cnt_d = r_edge_cnt + 8'd1;
          if (r_edge_cnt == LAST_EDGE) begin
            w_state_d   = StDone;
            w_done_d    = 1'b1;
            w_busy_d    = CONT;
            w_period_d  = w_cnt_inc;
            w_timeout_d = 1'b0;
            w_match_d   = EXP_FITS && (w_cnt_inc == EXP_VAL) && !w_cnt_sat;
            if (CONT) begin
              // The closing edge also opens the next window.
              w_cnt_d      = '0;
              w_edge_cnt_d = '0;
            end
          end
        end else if (w_wdog_expire) begin
          w_state_d   = StDone;
          w_done_d    = 1'b1;
          w_busy_d    = CONT;
          w_period_d  = '0;
          w_match_d   = 1'b0;
          w_timeout_d = 1'b1;
        end
      end

      StDone: begin
        if (CONT) begin
          w_busy_d = 1'b1;
          if (r_timeout) begin
            w_state_d    = StWaitEdge;
            w_wdog_d     = '0;
            w_edge_cnt_d = '0;
          end else begin
            // Edge pulses are at least two cycles apart, so none can land here.
            w_state_d = StMeasure;
            w_cnt_d   = w_cnt_inc;
            w_wdog_d  = w_wdog_inc;
          end
        end else begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (CONT && !start) begin
      w_state_d   = StIdle;
      w_busy_d    = 1'b0;
      w_done_d    = 1'b0;
      w_period_d  = r_period;
      w_match_d   = r_match;
      w_timeout_d = r_timeout;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_hist     <= 1'b0;
      r_cnt      <= '0;
      r_edge_cnt <= '0;
      r_wdog     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_period   <= '0;
      r_match    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_sync1    <= clk_test;
      r_sync2    <= r_sync1;
      r_hist     <= r_sync2;
      r_cnt      <= w_cnt_d;
      r_edge_cnt <= w_edge_cnt_d;
      r_wdog     <= w_wdog_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_period   <= w_period_d;
      r_match    <= w_match_d;
      r_timeout  <= w_timeout_d;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign period_count = r_period;
  assign match        = r_match;
  assign timeout      = r_timeout;

endmodule
